// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencing for a 1-cycle imem with a 3-entry credit-limited instruction queue.
// Define IFETCH_STATS_EN to add fetch_count/stall_count counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif

module imem_fetch_ctrl #(
    parameter int          DATA_WIDTH = `DATA_WIDTH,
    parameter int          ADDR_WIDTH = `IMEM_ADDR_WIDTH,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    input  logic                  imem_read_data_valid,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [31:0]           instr_pc,
    input  logic                  instr_ready
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);
    logic [31:0]           pc, inflight_pc, redirect_word;
    logic                  inflight;
    logic [1:0]            count, wr_idx;
    logic [DATA_WIDTH-1:0] q_instr [3];
    logic [31:0]           q_pc [3];
    logic                  resp, push, miss, issue, pop;

    assign redirect_word = redirect_pc & ~32'h3;
    assign imem_address  = pc[ADDR_WIDTH+1:2];
    assign instr_valid   = count != 2'd0;
    assign instr         = q_instr[0];
    assign instr_pc      = q_pc[0];

    // count + inflight never exceeds 3, so a push always finds a free slot
    always_comb begin
        resp   = inflight && !redirect_valid;
        push   = resp && imem_read_data_valid;
        miss   = resp && !imem_read_data_valid;
        issue  = !redirect_valid && !miss && (({1'b0, count} + {2'b0, inflight}) < 3'd3);
        pop    = instr_valid && instr_ready && !redirect_valid;
        wr_idx = count - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            count       <= 2'd0;
            q_instr     <= '{default: '0};
            q_pc        <= '{default: '0};
        end else begin
            inflight <= issue;
            if (issue)
                inflight_pc <= pc;
            pc    <= redirect_valid ? redirect_word : miss ? inflight_pc : issue ? pc + 32'd4 : pc;
            count <= redirect_valid ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                q_instr[0] <= q_instr[1];
                q_instr[1] <= q_instr[2];
                q_pc[0]    <= q_pc[1];
                q_pc[1]    <= q_pc[2];
            end
            if (push) begin
                q_instr[wr_idx] <= imem_read_data;
                q_pc[wr_idx]    <= inflight_pc;
            end
        end
    end

`ifdef IFETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            fetch_count <= fetch_count + 32'(pop);
            stall_count <= stall_count + 32'(instr_valid && !instr_ready);
        end
    end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed cycle-exact checks of imem_fetch_ctrl against a simple imem model.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_address;
    logic [31:0] imem_read_data = 32'h0;
    logic        imem_read_data_valid = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef IFETCH_STATS_EN
    logic [31:0] fetch_count, stall_count;
`endif
    int vectors = 0;
    int miscompares = 0;

    imem_fetch_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .imem_address(imem_address),
        .imem_read_data(imem_read_data),
        .imem_read_data_valid(imem_read_data_valid),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
`ifdef IFETCH_STATS_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // word at address a holds 0x11*(a+1): words 0..3 = 0x11,0x22,0x33,0x44
    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'h11 * (32'(a) + 32'd1);
    endfunction

    always_ff @(posedge clk) imem_read_data <= mem_word(imem_address);

    // leaves the bench at the negedge that ends the first post-reset cycle boundary (cycle 0 follows)
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_read_data_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if ({instr_valid, instr, instr_pc, imem_address} !== {1'b0, 32'h0, 32'h0, 10'h0}) begin
            miscompares++;
            $display("FAIL reset: valid=%0b instr=%h pc=%h addr=%h, required 0/0/0/0", instr_valid, instr, instr_pc, imem_address);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_cycle1: valid=%0b required 0", instr_valid);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ep = 32'(k) * 32'd4;
            vectors++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, mem_word(10'(k)), ep}) begin
                miscompares++;
                $display("FAIL stream_%0d: valid=%0b instr=%h pc=%h, required 1 %h %h", k, instr_valid, instr, instr_pc, mem_word(10'(k)), ep);
            end
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        do_reset();
        @(negedge clk);
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            vectors++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h11, 32'h0}) begin
                miscompares++;
                $display("FAIL hold_c%0d: valid=%0b instr=%h pc=%h, required 1 00000011 00000000", c, instr_valid, instr, instr_pc);
            end
            if (c >= 4) begin
                vectors++;
                if (imem_address !== 10'd3) begin
                    miscompares++;
                    $display("FAIL addr_stall_c%0d: addr=%h required 003", c, imem_address);
                end
            end
        end
        instr_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, mem_word(10'(k)), 32'(k) * 32'd4}) begin
                miscompares++;
                $display("FAIL release_%0d: valid=%0b instr=%h pc=%h, required 1 %h %h", k, instr_valid, instr, instr_pc, mem_word(10'(k)), 32'(k) * 32'd4);
            end
        end
    endtask

    task automatic test_redirect();
        instr_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++;
        if ({instr_valid, imem_address} !== {1'b0, 10'h040}) begin
            miscompares++;
            $display("FAIL redir_r1: valid=%0b addr=%h, required 0 040", instr_valid, imem_address);
        end
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_r2: valid=%0b required 0", instr_valid);
        end
        @(negedge clk);
        vectors++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h451, 32'h100}) begin
            miscompares++;
            $display("FAIL redir_r3: valid=%0b instr=%h pc=%h, required 1 00000451 00000100", instr_valid, instr, instr_pc);
        end
        @(negedge clk);
        vectors++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h462, 32'h104}) begin
            miscompares++;
            $display("FAIL redir_r4: valid=%0b instr=%h pc=%h, required 1 00000462 00000104", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_miss();
        logic [1:0]  ev [8];
        logic [31:0] ep [8];
        ev = '{0, 0, 1, 1, 0, 0, 1, 1};
        ep = '{0, 0, 0, 4, 0, 0, 8, 12};
        instr_ready = 1'b1;
        do_reset();
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            imem_read_data_valid = (c != 3);
            if (c == 3 || c == 4) begin
                vectors++;
                if (imem_address !== ((c == 3) ? 10'd3 : 10'd2)) begin
                    miscompares++;
                    $display("FAIL miss_addr_c%0d: addr=%h required %h", c, imem_address, (c == 3) ? 10'd3 : 10'd2);
                end
            end
            vectors++;
            if (instr_valid !== ev[c][0] || (ev[c][0] && (instr_pc !== ep[c] || instr !== mem_word(ep[c][11:2])))) begin
                miscompares++;
                $display("FAIL miss_c%0d: valid=%0b instr=%h pc=%h, required %0b %h %h", c, instr_valid, instr, instr_pc, ev[c][0], mem_word(ep[c][11:2]), ep[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: valid=%0b required 1", instr_valid);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({instr_valid, instr, instr_pc, imem_address} !== {1'b0, 32'h0, 32'h0, 10'h0}) begin
            miscompares++;
            $display("FAIL mid_async: valid=%0b instr=%h pc=%h addr=%h, required 0/0/0/0", instr_valid, instr, instr_pc, imem_address);
        end
        @(negedge clk);
        rst = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_c1: valid=%0b required 0", instr_valid);
        end
        @(negedge clk);
        vectors++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h11, 32'h0}) begin
            miscompares++;
            $display("FAIL mid_c2: valid=%0b instr=%h pc=%h, required 1 00000011 00000000", instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ep [3];
        ep = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        instr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFB;
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++;
        if ({instr_valid, imem_address} !== {1'b0, 10'h3FE}) begin
            miscompares++;
            $display("FAIL wrap_r1: valid=%0b addr=%h, required 0 3fe", instr_valid, imem_address);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, mem_word(ep[k][11:2]), ep[k]}) begin
                miscompares++;
                $display("FAIL wrap_%0d: valid=%0b instr=%h pc=%h, required 1 %h %h", k, instr_valid, instr, instr_pc, mem_word(ep[k][11:2]), ep[k]);
            end
        end
    endtask

`ifdef IFETCH_STATS_EN
    task automatic test_stats();
        instr_ready = 1'b1;
        do_reset();
        repeat (12) @(negedge clk);
        instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({fetch_count, stall_count} !== {32'd10, 32'd4}) begin
            miscompares++;
            $display("FAIL stats: fetch=%0d stall=%0d, required 10 4", fetch_count, stall_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_miss();
        test_reset_mid();
        test_wrap();
`ifdef IFETCH_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
